pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register; the next generation of the fixed-width stage registers between IF/ID/EX/MEM/WB.
- Carries NUM_FIELDS packed fields of DATA_W bits each (e.g. pc, rs1, rs2, imm).
- Uses a valid/ready handshake, so a stage stalls by holding its data instead of zeroing it.
- Has a dedicated flush input for bubble insertion on a taken branch or jump, an optional skid entry that breaks the combinational ready path, and a saturating bubble counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a valid/ready
// handshake, synchronous flush, an optional skid entry and a saturating
// bubble counter.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   flush       kill all held entries at this edge (taken branch/jump)
//   in_valid    upstream has data
//   in_ready    stage can accept data this cycle
//   in_data     upstream payload, field k at [k*DATA_W +: DATA_W]
//   out_valid   out_data is a real instruction
//   out_ready   downstream accepts this cycle
//   out_data    payload, or BUBBLE_VAL in every field when invalid
//   occupancy   number of valid entries held
//   bubble_cnt  saturating count of cycles with out_valid=0
module pipe_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_FIELDS = 4,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(32'h0000_0013),
  parameter int                SKID       = 0,
  parameter int                CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W*NUM_FIELDS-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W*NUM_FIELDS-1:0] out_data,
  output logic [1:0]                   occupancy,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int W = DATA_W * NUM_FIELDS;
  localparam logic [W-1:0] BUBBLE_REP = {NUM_FIELDS{BUBBLE_VAL}};

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  generate
    if (SKID == 0) begin : g_single
      assign skid_valid = 1'b0;
      assign in_ready   = !main_valid || out_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= BUBBLE_REP;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (in_xfer) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else if (out_xfer) begin
          main_valid <= 1'b0;
        end
      end
    end else begin : g_skid
      logic         skid_q;
      logic [W-1:0] skid_data;

      assign skid_valid = skid_q;
      // Registered ready: only the skid flag gates acceptance, so there is
      // no combinational path from out_ready back to in_ready.
      assign in_ready   = !skid_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= BUBBLE_REP;
          skid_q     <= 1'b0;
          skid_data  <= BUBBLE_REP;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_q     <= 1'b0;
        end else if (out_xfer) begin
          if (skid_q) begin
            // in_ready is 0 here, so no input can arrive this cycle.
            main_data <= skid_data;
            skid_q    <= 1'b0;
          end else if (in_xfer) begin
            main_data <= in_data;
          end else begin
            main_valid <= 1'b0;
          end
        end else if (in_xfer) begin
          if (!main_valid) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
          end else begin
            skid_q    <= 1'b1;
            skid_data <= in_data;
          end
        end
      end
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : BUBBLE_REP;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (!main_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [127:0] BUB = {4{32'h0000_0013}};

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;

  logic         rdy0, ov0, rdy1, ov1, rdy2, ov2;
  logic [127:0] od0, od1, od2;
  logic [1:0]   occ0, occ1, occ2;
  logic [15:0]  bc0, bc1;
  logic [3:0]   bc2;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(occ0), .bubble_cnt(bc0));

  pipe_stage_reg #(.SKID(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1), .bubble_cnt(bc1));

  pipe_stage_reg #(.SKID(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .occupancy(occ2), .bubble_cnt(bc2));

  function automatic logic [127:0] pk(input logic [31:0] f0, f1, f2, f3);
    return {f3, f2, f1, f0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] da, db, dc;

  initial begin
    da = pk(32'h100, 32'h1, 32'h2, 32'h3);
    db = pk(32'h104, 32'h5, 32'h6, 32'h7);
    dc = pk(32'h200, 32'h9, 32'ha, 32'hb);

    // reset held with in_valid high
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = da;
    tick(); tick();
    check("rst_ov0", ov0, 0);
    check("rst_od0", od0, BUB);
    check("rst_bc0", bc0, 0);
    check("rst_ov1", ov1, 0);
    check("rst_od1", od1, BUB);
    check("rst_rdy1", rdy1, 1);
    check("rst_occ1", occ1, 0);

    rst = 1'b1; in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("idle_bc0", bc0, i);
      check("idle_bc1", bc1, i);
    end

    // streaming
    in_valid = 1'b1; out_ready = 1'b1; in_data = da;
    tick();
    check("strA_od0", od0, da);  check("strA_ov0", ov0, 1);
    check("strA_rdy0", rdy0, 1); check("strA_occ0", occ0, 1);
    check("strA_od1", od1, da);  check("strA_rdy1", rdy1, 1);
    in_data = db;
    tick();
    check("strB_od0", od0, db);  check("strB_rdy0", rdy0, 1);
    check("strB_od1", od1, db);  check("strB_occ1", occ1, 1);
    in_valid = 1'b0;
    tick();
    check("drn_ov0", ov0, 0);    check("drn_od0", od0, BUB);
    check("drn_ov1", ov1, 0);

    // stall hold
    in_valid = 1'b1; out_ready = 1'b0; in_data = da;
    tick();
    check("stl_rdy0", rdy0, 0);  check("stl_rdy1", rdy1, 1);
    check("stl_occ1", occ1, 1);
    in_data = db;
    tick();
    check("stl2_od0", od0, da);  check("stl2_rdy0", rdy0, 0);
    check("stl2_occ0", occ0, 1);
    check("stl2_od1", od1, da);  check("stl2_occ1", occ1, 2);
    check("stl2_rdy1", rdy1, 0);
    tick();
    check("stl3_od0", od0, da);  check("stl3_od1", od1, da);
    check("stl3_occ1", occ1, 2); check("stl3_bc1", bc1, 5);

    // skid drain
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("comb_rdy0", rdy0, 1); check("reg_rdy1", rdy1, 0);
    tick();
    check("sd1_od1", od1, db);   check("sd1_ov1", ov1, 1);
    check("sd1_occ1", occ1, 1);  check("sd1_rdy1", rdy1, 1);
    check("sd1_ov0", ov0, 0);
    tick();
    check("sd2_ov1", ov1, 0);    check("sd2_od1", od1, BUB);

    // flush with occupancy 2
    in_valid = 1'b1; out_ready = 1'b0; in_data = da;
    tick();
    in_data = db;
    tick();
    check("fl_pre_occ1", occ1, 2);
    flush = 1'b1; in_data = dc;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_ov1", ov1, 0);     check("fl_occ1", occ1, 0);
    check("fl_od1", od1, BUB);   check("fl_ov0", ov0, 0);
    check("fl_od0", od0, BUB);   check("fl_bc1", bc1, 6);
    tick();
    check("fl2_ov1", ov1, 0);    check("fl2_od1", od1, BUB);
    check("fl2_bc1", bc1, 7);    check("fl2_bc0", bc0, 8);

    // async reset between edges
    in_valid = 1'b1; out_ready = 1'b0; in_data = da;
    tick();
    check("ar_pre_ov0", ov0, 1);
    rst = 1'b0;
    #1;
    check("ar_ov0", ov0, 0);     check("ar_od0", od0, BUB);
    check("ar_occ0", occ0, 0);   check("ar_bc0", bc0, 0);
    check("ar_ov1", ov1, 0);     check("ar_occ1", occ1, 0);
    rst = 1'b1; in_valid = 1'b0;

    // saturation
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i >= 14) check("sat_bc2", bc2, (i > 15) ? 15 : i);
    end
    check("sat_bc0", bc0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
